// File: rtl/spi_flash_block.sv
// Single-shot SPI (mode 0) master: after reset it sends {CMD, ADDR} MSB first,
// then reads NUM_BYTES response bytes from a serial NOR flash. SCK = clk/2.
module spi_flash_block #(
  parameter logic [7:0]  CMD       = 8'h90,
  parameter logic [23:0] ADDR      = 24'h000000,
  parameter int unsigned NUM_BYTES = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic       out_bit,
  input  logic       out,
  output logic [7:0] data_out_sim,
  output logic       chip_select,
  output logic       data_clk
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_OUT,
    SHIFT_IN,
    DONE
  } state_t;

  localparam int unsigned BYTE_W = (NUM_BYTES < 2) ? 1 : $clog2(NUM_BYTES);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);
  localparam logic [BYTE_W-1:0] BYTE_ONE  = BYTE_W'(1);
  localparam logic [5:0]        LAST_TX_BIT = 6'd31;
  localparam logic [5:0]        BITS_PER_BYTE = 6'd8;

  state_t            state_q, state_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [31:0]       tx_sr_q, tx_sr_d;
  logic [7:0]        rx_sr_q, rx_sr_d;
  logic              cs_d, sck_d, mosi_d;
  logic [7:0]        dout_d;

  // NOTE: reset is sampled on the clock edge only (synchronous), and every
  // register uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      tx_sr_q      <= '0;
      rx_sr_q      <= '0;
      chip_select  <= 1'b1;
      data_clk     <= 1'b0;
      out_bit      <= 1'b0;
      data_out_sim <= 8'h00;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      tx_sr_q      <= tx_sr_d;
      rx_sr_q      <= rx_sr_d;
      chip_select  <= cs_d;
      data_clk     <= sck_d;
      out_bit      <= mosi_d;
      data_out_sim <= dout_d;
    end
  end

  // Next-state logic; outputs are computed here as next values and registered above.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    cs_d       = chip_select;
    sck_d      = 1'b0;
    mosi_d     = out_bit;
    dout_d     = data_out_sim;

    unique case (state_q)
      IDLE: begin
        cs_d      = 1'b0;
        mosi_d    = CMD[7];
        tx_sr_d   = {CMD[6:0], ADDR, 1'b0};
        bit_cnt_d = '0;
        state_d   = SHIFT_OUT;
      end

      SHIFT_OUT: begin
        cs_d  = 1'b0;
        sck_d = ~data_clk;
        // The flash samples on the rising edge; present the next bit on the falling edge.
        if (data_clk) begin
          if (bit_cnt_q == LAST_TX_BIT) begin
            state_d    = SHIFT_IN;
            mosi_d     = 1'b0;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            rx_sr_d    = '0;
          end else begin
            mosi_d    = tx_sr_q[31];
            tx_sr_d   = {tx_sr_q[30:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
      end

      SHIFT_IN: begin
        cs_d   = 1'b0;
        mosi_d = 1'b0;
        sck_d  = ~data_clk;
        if (!data_clk) begin
          // Rising SCK edge: the flash updated SO on the previous falling edge.
          rx_sr_d   = {rx_sr_q[6:0], out};
          bit_cnt_d = bit_cnt_q + 6'd1;
        end else if (bit_cnt_q == BITS_PER_BYTE) begin
          dout_d    = rx_sr_q;
          bit_cnt_d = '0;
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = DONE;
          end else begin
            byte_cnt_d = byte_cnt_q + BYTE_ONE;
          end
        end
      end

      DONE: begin
        cs_d   = 1'b1;
        mosi_d = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_flash_block.sv
// Bench for spi_flash_block: two instances (ID read, data read) against a
// behavioural S25FL032P-style flash model plus per-cycle SPI protocol checks.
module tb_spi_flash_block;

  logic clk = 1'b0;
  always #20 clk = ~clk;  // 25 MHz

  logic       rst  [2];
  logic       so   [2];
  logic       mosi [2];
  logic       cs   [2];
  logic       sck  [2];
  logic [7:0] dout [2];

  spi_flash_block #(.CMD(8'h90), .ADDR(24'h000000), .NUM_BYTES(2)) u_id (
    .clk(clk), .reset(rst[0]), .out_bit(mosi[0]), .out(so[0]),
    .data_out_sim(dout[0]), .chip_select(cs[0]), .data_clk(sck[0])
  );

  spi_flash_block #(.CMD(8'h03), .ADDR(24'h000010), .NUM_BYTES(4)) u_rd (
    .clk(clk), .reset(rst[1]), .out_bit(mosi[1]), .out(so[1]),
    .data_out_sim(dout[1]), .chip_select(cs[1]), .data_clk(sck[1])
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0]  image [256];
  int          rise_cnt [2], fall_cnt [2], rbit [2], got_n [2];
  int          rel_cyc [2], cs_fall_cyc [2], cs_rise_cyc [2];
  int          rise1_cyc [2], rise32_cyc [2], fall32_cyc [2], last_fall_cyc [2];
  logic [31:0] hdr [2];
  logic [7:0]  got [2][8];
  logic        p_sck [2], p_cs [2], p_mosi [2], p_rst [2];
  logic        rose, fell;
  logic [7:0]  fb;

  // What the flash returns for response byte k of a command word.
  function automatic logic [7:0] flash_byte(input logic [31:0] h, input int k);
    logic [7:0]  c;
    logic [23:0] a;
    c = h[31:24];
    a = h[23:0];
    if (c == 8'h90) return (((k + int'(a[0])) % 2) == 0) ? 8'h01 : 8'h15;
    if (c == 8'h03) return image[8'(a + 24'(k))];
    return 8'hFF;
  endfunction

  // Flash model and protocol monitor, sampled 1 time unit after each clk edge.
  initial begin
    for (int i = 0; i < 2; i++) begin
      p_sck[i] = 1'b0; p_cs[i] = 1'b1; p_mosi[i] = 1'b0; p_rst[i] = 1'b1; so[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (rst[i]) begin
          total++;
          if (cs[i] !== 1'b1 || sck[i] !== 1'b0 || mosi[i] !== 1'b0 || dout[i] !== 8'h00) begin
            bad++;
            $display("FAIL reset_values inst%0d cyc%0d: cs=%b sck=%b mosi=%b dout=%h, want cs=1 sck=0 mosi=0 dout=00",
                     i, cyc, cs[i], sck[i], mosi[i], dout[i]);
          end
          rise_cnt[i] = 0; fall_cnt[i] = 0; rbit[i] = 0; got_n[i] = 0; hdr[i] = '0;
          cs_fall_cyc[i] = 0; cs_rise_cyc[i] = 0; rise1_cyc[i] = 0; rise32_cyc[i] = 0;
          fall32_cyc[i] = 0; last_fall_cyc[i] = 0; so[i] = 1'b0;
        end else begin
          if (p_rst[i]) rel_cyc[i] = cyc;
          rose = sck[i] & ~p_sck[i];
          fell = ~sck[i] & p_sck[i];
          total++;
          if (((rose || fell) && cs[i]) ||
              ((cs[i] != p_cs[i]) && (sck[i] || p_sck[i])) ||
              ((mosi[i] != p_mosi[i]) && !fell && !(p_cs[i] && !cs[i]))) begin
            bad++;
            $display("FAIL protocol inst%0d cyc%0d: cs %b->%b sck %b->%b mosi %b->%b, want no SCK edge with CS high, SCK low on CS change, MOSI change only on SCK fall/CS fall",
                     i, cyc, p_cs[i], cs[i], p_sck[i], sck[i], p_mosi[i], mosi[i]);
          end
          if (!cs[i] && p_cs[i]) cs_fall_cyc[i] = cyc;
          if (cs[i] && !p_cs[i]) cs_rise_cyc[i] = cyc;
          if (cs[i]) begin
            so[i] = 1'b0;
          end else begin
            if (rose) begin
              rise_cnt[i]++;
              if (rise_cnt[i] == 1) rise1_cyc[i] = cyc;
              if (rise_cnt[i] == 32) rise32_cyc[i] = cyc;
              if (rise_cnt[i] <= 32) hdr[i] = {hdr[i][30:0], mosi[i]};
            end
            if (fell) begin
              fall_cnt[i]++;
              last_fall_cyc[i] = cyc;
              if (fall_cnt[i] == 32) fall32_cyc[i] = cyc;
              if (fall_cnt[i] > 32 && ((fall_cnt[i] - 32) % 8) == 0 && got_n[i] < 8) begin
                got[i][got_n[i]] = dout[i];
                got_n[i]++;
              end
              if (fall_cnt[i] >= 32) begin
                fb = flash_byte(hdr[i], rbit[i] / 8);
                so[i] = fb[7 - (rbit[i] % 8)];
                rbit[i]++;
              end
            end
          end
        end
        p_sck[i] = sck[i]; p_cs[i] = cs[i]; p_mosi[i] = mosi[i]; p_rst[i] = rst[i];
      end
    end
  end

  initial begin
    #(40 * 200000);
    $display("FAIL watchdog: simulation did not finish, want finish within 200000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic wait_cs_high(input int i, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (cs_rise_cyc[i] != 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    repeat (25000) @(negedge clk);  // 1 ms flash power-up
    for (int i = 0; i < 2; i++) begin
      total++;
      if (cs[i] !== 1'b1 || sck[i] !== 1'b0 || mosi[i] !== 1'b0 || dout[i] !== 8'h00) begin
        bad++;
        $display("FAIL reset_end inst%0d: cs=%b sck=%b mosi=%b dout=%h, want 1 0 0 00",
                 i, cs[i], sck[i], mosi[i], dout[i]);
      end
    end
  endtask

  task automatic test_id_read();
    bit ok;
    int rises;
    @(negedge clk);
    rst[0] = 1'b0;
    wait_cs_high(0, 400, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL id_timeout: cs_rise_seen=%0b, want 1", ok); end
    total++;
    if (cs_fall_cyc[0] != rel_cyc[0]) begin
      bad++; $display("FAIL id_cs_fall: cycle %0d, want %0d", cs_fall_cyc[0], rel_cyc[0]);
    end
    total++;
    if (hdr[0] !== 32'h90000000) begin
      bad++; $display("FAIL id_mosi_word: got %h, want 90000000", hdr[0]);
    end
    total++;
    if (rise1_cyc[0] != cs_fall_cyc[0] + 1 || rise32_cyc[0] - rise1_cyc[0] != 62 ||
        fall32_cyc[0] - rise1_cyc[0] != 63) begin
      bad++;
      $display("FAIL id_sck_timing: rise1-csfall=%0d rise32-rise1=%0d fall32-rise1=%0d, want 1 62 63",
               rise1_cyc[0] - cs_fall_cyc[0], rise32_cyc[0] - rise1_cyc[0], fall32_cyc[0] - rise1_cyc[0]);
    end
    total++;
    if (rise_cnt[0] != 48 || fall_cnt[0] != 48) begin
      bad++; $display("FAIL id_edge_count: rises=%0d falls=%0d, want 48 48", rise_cnt[0], fall_cnt[0]);
    end
    total++;
    if (got_n[0] != 2 || got[0][0] !== 8'h01 || got[0][1] !== 8'h15) begin
      bad++;
      $display("FAIL id_bytes: n=%0d b0=%h b1=%h, want n=2 01 15", got_n[0], got[0][0], got[0][1]);
    end
    total++;
    if (cs_rise_cyc[0] != last_fall_cyc[0] + 1) begin
      bad++; $display("FAIL id_cs_rise: %0d cycles after last fall, want 1", cs_rise_cyc[0] - last_fall_cyc[0]);
    end
    rises = rise_cnt[0];
    repeat (40) @(negedge clk);
    total++;
    if (rise_cnt[0] != rises || cs[0] !== 1'b1 || dout[0] !== 8'h15) begin
      bad++;
      $display("FAIL id_done_hold: extra_rises=%0d cs=%b dout=%h, want 0 1 15", rise_cnt[0] - rises, cs[0], dout[0]);
    end
  endtask

  task automatic test_read_run(input string tag, input int hold);
    bit ok;
    @(negedge clk);
    rst[1] = 1'b1;
    repeat (hold) @(negedge clk);
    rst[1] = 1'b0;
    wait_cs_high(1, 600, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL %s_timeout: cs_rise_seen=%0b, want 1", tag, ok); end
    total++;
    if (hdr[1] !== 32'h03000010) begin
      bad++; $display("FAIL %s_mosi_word: got %h, want 03000010", tag, hdr[1]);
    end
    total++;
    if (got_n[1] != 4 || rise_cnt[1] != 64) begin
      bad++; $display("FAIL %s_count: bytes=%0d rises=%0d, want 4 64", tag, got_n[1], rise_cnt[1]);
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (got[1][k] !== image[16 + k]) begin
        bad++; $display("FAIL %s_byte%0d: got %h, want %h", tag, k, got[1][k], image[16 + k]);
      end
    end
    total++;
    if (cs_rise_cyc[1] != last_fall_cyc[1] + 1 || dout[1] !== image[19]) begin
      bad++;
      $display("FAIL %s_end: cs_rise-lastfall=%0d dout=%h, want 1 %h",
               tag, cs_rise_cyc[1] - last_fall_cyc[1], dout[1], image[19]);
    end
  endtask

  task automatic test_read();
    image[16] = 8'hA5; image[17] = 8'h5A; image[18] = 8'h00; image[19] = 8'hFF;
    test_read_run("read_fixed", 2);
  endtask

  task automatic test_read_random();
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < 256; a++) image[a] = 8'($urandom);
      test_read_run("read_rand", $urandom_range(1, 6));
    end
  endtask

  task automatic test_reset_mid();
    int   tgt [3];
    bit   hit, ok;
    logic [7:0] exp_pre;
    tgt[0] = 28;                        // 20th address bit
    tgt[1] = 41 + $urandom_range(0, 6); // inside the second response byte
    tgt[2] = $urandom_range(1, 47);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      rst[0] = 1'b1;
      repeat ($urandom_range(2, 6)) @(negedge clk);
      rst[0] = 1'b0;
      hit = 1'b0;
      for (int n = 0; n < 300; n++) begin
        @(negedge clk);
        if (rise_cnt[0] >= tgt[t]) begin hit = 1'b1; break; end
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      total++;
      if (!hit) begin bad++; $display("FAIL abort_wait t%0d: reached=%0b, want 1", t, hit); end
      exp_pre = (rise_cnt[0] >= 41) ? 8'h01 : 8'h00;
      total++;
      if (dout[0] !== exp_pre) begin
        bad++; $display("FAIL abort_pre_dout t%0d: got %h, want %h", t, dout[0], exp_pre);
      end
      rst[0] = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (cs[0] !== 1'b1 || sck[0] !== 1'b0 || dout[0] !== 8'h00) begin
        bad++;
        $display("FAIL abort_outputs t%0d: cs=%b sck=%b dout=%h, want 1 0 00", t, cs[0], sck[0], dout[0]);
      end
      repeat ($urandom_range(1, 4)) @(negedge clk);
      rst[0] = 1'b0;
      wait_cs_high(0, 400, ok);
      total++;
      if (!ok || hdr[0] !== 32'h90000000 || got_n[0] != 2 || got[0][0] !== 8'h01 || got[0][1] !== 8'h15) begin
        bad++;
        $display("FAIL abort_restart t%0d: done=%0b word=%h n=%0d b0=%h b1=%h, want 1 90000000 2 01 15",
                 t, ok, hdr[0], got_n[0], got[0][0], got[0][1]);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) image[a] = 8'($urandom);
    test_reset();
    test_id_read();
    test_read();
    test_read_random();
    test_reset_mid();
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
